// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 8N1 UART receiver, LSB first, oversampled on hwclk with a
//                valid/ready output, framing-error and overrun pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int SOURCE_CLK = 12000000,
    parameter int TARGET_CLK = 9600,
    parameter int N          = SOURCE_CLK / TARGET_CLK,
    parameter int HALF       = N / 2
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       ftdi_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int               c_cnt_w    = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(HALF - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic               r_sync;
    logic               r_rx_s;
    logic               r_prev;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_deliver;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         w_bit_nxt;
    logic               w_shift_en;
    logic               w_stop_ok;
    logic               w_stop_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_en  = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                // Only a genuine high-to-low transition arms the receiver, so a
                // line stuck low after a break stays quiet.
                if (r_prev && !r_rx_s) begin
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                if (r_cnt == c_cnt_half) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = r_rx_s ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    w_bit_nxt  = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_st_stop;
                    end
                end
            end
            c_st_stop: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_idle;
                    w_stop_ok   = r_rx_s;
                    w_stop_bad  = !r_rx_s;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_sync      <= 1'b1;
            r_rx_s      <= 1'b1;
            r_prev      <= 1'b1;
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_deliver   <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= ftdi_rx;
            r_rx_s      <= r_sync;
            r_prev      <= r_rx_s;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_deliver   <= w_stop_ok;
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
            if (r_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Directed scoreboard bench for uart_rx_core (N=16 and N=100).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    logic       hwclk = 1'b0;
    logic       rst   = 1'b1;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic       ready_a = 1'b1;
    logic       ready_b = 1'b1;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       ovr_a, ovr_b;
    logic       busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ferr_a = 0, n_ovr_a = 0, n_busy_a = 0, n_ferr_b = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] exp_a, exp_b;

    always #5 hwclk = ~hwclk;

    uart_rx_core #(.SOURCE_CLK(16), .TARGET_CLK(1)) dut_a (
        .hwclk(hwclk), .rst(rst), .ftdi_rx(line_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_ready(ready_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_core #(.SOURCE_CLK(1200000), .TARGET_CLK(12000)) dut_b (
        .hwclk(hwclk), .rst(rst), .ftdi_rx(line_b), .rx_data(data_b),
        .rx_valid(valid_b), .rx_ready(ready_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    // bits[0] is the start bit, bits[9] the stop bit
    task automatic drive_bits(input bit sel, input logic [9:0] bits, input int per);
        for (int i = 0; i < 10; i++) begin
            if (sel) line_b = bits[i];
            else     line_a = bits[i];
            wait_cyc(per);
        end
    endtask

    always @(negedge hwclk) begin
        if (ferr_a) n_ferr_a++;
        if (ovr_a)  n_ovr_a++;
        if (busy_a) n_busy_a++;
        if (ferr_b) n_ferr_b++;
        if (!rst && valid_a && ready_a) begin
            check("sb_a_pending", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) begin
                exp_a = q_a.pop_front();
                check("sb_a_data", {24'b0, data_a}, {24'b0, exp_a});
            end
        end
        if (!rst && valid_b && ready_b) begin
            check("sb_b_pending", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
                exp_b = q_b.pop_front();
                check("sb_b_data", {24'b0, data_b}, {24'b0, exp_b});
            end
        end
    end

    initial begin
        int cyc;
        int snap_f, snap_o, snap_b;

        // 1: reset and idle line
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(100);
        check("reset_outputs", {20'b0, data_a, valid_a, ferr_a, ovr_a, busy_a}, 32'd0);
        check("reset_pulses", n_ferr_a + n_ovr_a + n_busy_a, 32'd0);

        // 2: single byte, latency from first clock seeing the start edge
        q_a.push_back(8'h47);
        fork
            drive_bits(1'b0, {1'b1, 8'h47, 1'b0}, 16);
            begin
                cyc = 0;
                do begin
                    @(posedge hwclk);
                    #1;
                    cyc++;
                end while (!valid_a && cyc < 400);
                check("t2_latency", cyc - 1, 32'd155);
                wait_cyc(1);
                check("t2_valid_one_cycle", valid_a, 1'b0);
            end
        join
        wait_cyc(20);
        check("t2_sb_empty", q_a.size(), 32'd0);

        // 3: back-to-back with consumer stalled
        ready_a = 1'b0;
        snap_o  = n_ovr_a;
        q_a.push_back(8'h55);
        drive_bits(1'b0, {1'b1, 8'h55, 1'b0}, 16);
        drive_bits(1'b0, {1'b1, 8'hA3, 1'b0}, 16);
        wait_cyc(20);
        check("t3_overrun_count", n_ovr_a - snap_o, 32'd1);
        check("t3_valid_held", valid_a, 1'b1);
        check("t3_data_kept", {24'b0, data_a}, 32'h55);
        ready_a = 1'b1;
        wait_cyc(1);
        check("t3_valid_dropped", valid_a, 1'b0);

        // 4: stop bit low, then recovery
        snap_f = n_ferr_a;
        drive_bits(1'b0, {1'b0, 8'h00, 1'b0}, 16);
        line_a = 1'b1;
        wait_cyc(20);
        check("t4_ferr_count", n_ferr_a - snap_f, 32'd1);
        check("t4_no_valid", valid_a, 1'b0);
        q_a.push_back(8'h5A);
        drive_bits(1'b0, {1'b1, 8'h5A, 1'b0}, 16);
        wait_cyc(20);
        check("t4_sb_empty", q_a.size(), 32'd0);

        // 5: short glitch
        snap_f = n_ferr_a;
        snap_b = n_busy_a;
        line_a = 1'b0;
        wait_cyc(4);
        line_a = 1'b1;
        wait_cyc(40);
        check("t5_busy_seen", 32'(n_busy_a > snap_b), 32'd1);
        check("t5_back_idle", busy_a, 1'b0);
        check("t5_no_ferr", n_ferr_a - snap_f, 32'd0);
        check("t5_no_valid", valid_a, 1'b0);

        // 6: reset in the middle of a frame with a byte pending
        ready_a = 1'b0;
        drive_bits(1'b0, {1'b1, 8'h3C, 1'b0}, 16);
        wait_cyc(10);
        check("t6_pending_valid", valid_a, 1'b1);
        check("t6_pending_data", {24'b0, data_a}, 32'h3C);
        snap_f = n_ferr_a;
        fork
            drive_bits(1'b0, {1'b1, 8'hF5, 1'b0}, 16);
            begin
                wait_cyc(88);
                rst = 1'b1;
                wait_cyc(1);
                check("t6_reset_outputs", {20'b0, data_a, valid_a, ferr_a, ovr_a, busy_a}, 32'd0);
                rst = 1'b0;
            end
        join
        ready_a = 1'b1;
        wait_cyc(20);
        check("t6_remainder_silent", valid_a, 1'b0);
        q_a.push_back(8'h31);
        drive_bits(1'b0, {1'b1, 8'h31, 1'b0}, 16);
        wait_cyc(20);
        check("t6_sb_empty", q_a.size(), 32'd0);
        check("t6_no_ferr", n_ferr_a - snap_f, 32'd0);

        // 7: +/-2% baud error on the N=100 instance
        for (int i = 0; i < 24; i++) begin
            q_b.push_back(8'(i * 11));
            drive_bits(1'b1, {1'b1, 8'(i * 11), 1'b0}, 102);
        end
        for (int i = 0; i < 24; i++) begin
            q_b.push_back(8'(255 - i * 11));
            drive_bits(1'b1, {1'b1, 8'(255 - i * 11), 1'b0}, 98);
        end
        wait_cyc(200);
        check("t7_sb_empty", q_b.size(), 32'd0);
        check("t7_no_ferr", n_ferr_b, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
